// File: rtl/ptw_line_fetch_pkg.sv
// -----------------------------------------------------------------------------
// ptw_line_fetch_pkg
// Shared definitions for the page-table-walker line fetcher: the default
// cache-line geometry (taken from the data-cache bank layout), the derived
// line/beat/offset sizes and the fetch state machine encoding.
// -----------------------------------------------------------------------------
package ptw_line_fetch_pkg;

    // Data-cache line geometry the walker shares with the L1 data cache.
    localparam int DCACHE_BANK = 8;
    localparam int DCACHE_BITS = 32;
    localparam int BUS_W_DEF   = 64;

    // Bits in one returned line.
    function automatic int line_bits(input int banks, input int bank_bits);
        return banks * bank_bits;
    endfunction

    // Bus beats needed to move one line.
    function automatic int line_beats(input int lbits, input int bus_w);
        return lbits / bus_w;
    endfunction

    // Byte-offset bits inside a line; these are zeroed to line-align an address.
    function automatic int line_off(input int lbits);
        return $clog2(lbits / 8);
    endfunction

    // Counter width for n items, never less than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int LINE_BITS = line_bits(DCACHE_BANK, DCACHE_BITS);
    localparam int BEATS     = line_beats(LINE_BITS, BUS_W_DEF);
    localparam int OFF       = line_off(LINE_BITS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } ptw_state_e;

endpackage

// File: rtl/ptw_req_queue.sv
// -----------------------------------------------------------------------------
// ptw_req_queue
// Small FIFO holding pending page-table-entry addresses.
//   clk, rst      clock, asynchronous active-high reset (pointers/count only)
//   i_push/i_data write one entry (ignored when full)
//   i_pop         drop the head entry (ignored when empty)
//   i_clear       synchronous clear, wins over push/pop
//   o_head        current head entry
//   o_count       number of stored entries
//   o_full/o_empty occupancy flags
// -----------------------------------------------------------------------------
module ptw_req_queue
    import ptw_line_fetch_pkg::*;
#(
    parameter int W     = 32,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_push,
    input  logic [W-1:0]                 i_data,
    input  logic                         i_pop,
    input  logic                         i_clear,
    output logic [W-1:0]                 o_head,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_full,
    output logic                         o_empty
);

    localparam int PW = cnt_width(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr;
    logic [PW-1:0] r_rd;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd];

    assign w_push = i_push & ~o_full & ~i_clear;
    assign w_pop  = i_pop & ~o_empty & ~i_clear;

    // Storage carries data only, so it is not reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr] <= i_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wr <= ptr_next(r_wr);
            end
            if (w_pop) begin
                r_rd <= ptr_next(r_rd);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ptw_line_fetch.sv
// -----------------------------------------------------------------------------
// ptw_line_fetch
// Memory-side responder for the page-table walker. Queues PTE addresses,
// fetches each containing cache line with a single burst read and returns the
// whole line with a one-cycle data_valid pulse. One burst outstanding at most.
//   clk, rst          clock, asynchronous active-high reset
//   req/paddr         walker request, held until ready
//   ready/full        request accepted this cycle / queue full
//   flush             drop all queued and in-flight work
//   data_valid/rdata  line return pulse and line (bank i at [i*BANK_BITS +:])
//   err               bus or burst-framing error, qualified by data_valid
//   ar_*              burst read address channel
//   r_*               burst read data channel
// -----------------------------------------------------------------------------
module ptw_line_fetch
    import ptw_line_fetch_pkg::*;
#(
    parameter int PADDR_SIZE = 32,
    parameter int BANKS      = DCACHE_BANK,
    parameter int BANK_BITS  = DCACHE_BITS,
    parameter int BUS_WIDTH  = BUS_W_DEF,
    parameter int DEPTH      = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req,
    input  logic [PADDR_SIZE-1:0]         paddr,
    output logic                          ready,
    output logic                          full,
    input  logic                          flush,
    output logic                          data_valid,
    output logic [BANKS*BANK_BITS-1:0]    rdata,
    output logic                          err,
    output logic                          ar_valid,
    input  logic                          ar_ready,
    output logic [PADDR_SIZE-1:0]         ar_addr,
    output logic [7:0]                    ar_len,
    input  logic                          r_valid,
    output logic                          r_ready,
    input  logic [BUS_WIDTH-1:0]          r_data,
    input  logic [1:0]                    r_resp,
    input  logic                          r_last
);

    localparam int LB   = line_bits(BANKS, BANK_BITS);
    localparam int NB   = line_beats(LB, BUS_WIDTH);
    localparam int OFFB = line_off(LB);
    localparam int CW   = cnt_width(NB);
    localparam int QCW  = $clog2(DEPTH + 1);

    ptw_state_e             r_state;
    ptw_state_e             w_state_nxt;
    logic [CW-1:0]          r_cnt;
    logic                   r_err_acc;
    logic                   r_kill;
    logic [LB-1:0]          r_line;

    logic                   w_push;
    logic                   w_ar_hs;
    logic                   w_beat;
    logic                   w_final;
    logic                   w_work;
    logic                   w_empty;
    logic                   w_full;
    logic [QCW-1:0]         w_count;
    logic [PADDR_SIZE-1:0]  w_head;

    assign ready   = req & ~w_full & ~flush;
    assign full    = w_full;
    assign w_push  = ready;
    assign w_ar_hs = (r_state == ST_ADDR) & ar_ready;
    assign w_beat  = (r_state == ST_DATA) & r_valid;
    assign w_final = (r_cnt == CW'(NB - 1));
    // Counting a same-cycle push lets an idle fetcher raise ar_valid on the
    // cycle right after the request is accepted.
    assign w_work  = (~w_empty | w_push) & ~flush;
    assign rdata   = r_line;

    ptw_req_queue #(
        .W     (PADDR_SIZE),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (paddr),
        .i_pop   (w_ar_hs),
        .i_clear (flush),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        ar_valid    = 1'b0;
        ar_addr     = '0;
        ar_len      = '0;
        r_ready     = 1'b0;
        data_valid  = 1'b0;
        err         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_work) begin
                    w_state_nxt = ST_ADDR;
                end
            end
            ST_ADDR: begin
                ar_valid = 1'b1;
                ar_addr  = {w_head[PADDR_SIZE-1:OFFB], {OFFB{1'b0}}};
                ar_len   = 8'(NB - 1);
                // Once the address is taken the burst must be drained even if
                // a flush arrives on the same cycle; the kill flag hides it.
                if (ar_ready) begin
                    w_state_nxt = ST_DATA;
                end else if (flush) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_DATA: begin
                r_ready = 1'b1;
                if (w_beat && w_final) begin
                    w_state_nxt = (r_kill || flush) ? ST_IDLE : ST_RESP;
                end
            end
            ST_RESP: begin
                data_valid  = 1'b1;
                err         = r_err_acc;
                w_state_nxt = w_work ? ST_ADDR : ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_err_acc <= 1'b0;
            r_kill    <= 1'b0;
            r_line    <= '0;
        end else if (w_ar_hs) begin
            r_cnt     <= '0;
            r_err_acc <= 1'b0;
            r_kill    <= flush;
        end else if (w_beat) begin
            r_line[int'(r_cnt)*BUS_WIDTH +: BUS_WIDTH] <= r_data;
            if (!w_final) begin
                r_cnt <= r_cnt + 1'b1;
            end
            // Beat count frames the burst; r_last disagreeing with it is an error.
            r_err_acc <= r_err_acc | (|r_resp) | (r_last != w_final);
            if (flush) begin
                r_kill <= 1'b1;
            end
        end else if ((r_state == ST_DATA) && flush) begin
            r_kill <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ptw_line_fetch.sv
module tb_ptw_line_fetch;

    logic         clk = 1'b0;
    logic         rst;
    logic         req;
    logic [31:0]  paddr;
    logic         ready;
    logic         full;
    logic         flush;
    logic         data_valid;
    logic [255:0] rdata;
    logic         err;
    logic         ar_valid;
    logic         ar_ready;
    logic [31:0]  ar_addr;
    logic [7:0]   ar_len;
    logic         r_valid;
    logic         r_ready;
    logic [63:0]  r_data;
    logic [1:0]   r_resp;
    logic         r_last;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [63:0] STEP = 64'h1111_1111_1111_1111;

    ptw_line_fetch dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .paddr      (paddr),
        .ready      (ready),
        .full       (full),
        .flush      (flush),
        .data_valid (data_valid),
        .rdata      (rdata),
        .err        (err),
        .ar_valid   (ar_valid),
        .ar_ready   (ar_ready),
        .ar_addr    (ar_addr),
        .ar_len     (ar_len),
        .r_valid    (r_valid),
        .r_ready    (r_ready),
        .r_data     (r_data),
        .r_resp     (r_resp),
        .r_last     (r_last)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic send_beat(input logic [63:0] d, input logic [1:0] resp, input logic last);
        r_valid = 1'b1;
        r_data  = d;
        r_resp  = resp;
        r_last  = last;
        settle;
        chk("r_ready_on_beat", r_ready, 1'b1);
        tick;
        r_valid = 1'b0;
        r_last  = 1'b0;
        r_resp  = 2'd0;
    endtask

    // Sends a 4-beat line: beat i = base + i*STEP; r_resp=2 on beat resp_idx;
    // r_last on beats flagged in last_mask. Returns the line the walker should see.
    task automatic send_line(input logic [63:0] base, input int resp_idx,
                             input logic [3:0] last_mask, output logic [255:0] line);
        logic [63:0] d;
        line = '0;
        for (int i = 0; i < 4; i++) begin
            d = base + STEP * 64'(i);
            line[i*64 +: 64] = d;
            send_beat(d, (i == resp_idx) ? 2'd2 : 2'd0, last_mask[i]);
            if (i < 3) begin
                chk("no_dv_mid_burst", data_valid, 1'b0);
            end
        end
    endtask

    logic [255:0] line;

    initial begin
        rst      = 1'b1;
        req      = 1'b0;
        paddr    = '0;
        flush    = 1'b0;
        ar_ready = 1'b0;
        r_valid  = 1'b0;
        r_data   = '0;
        r_resp   = 2'd0;
        r_last   = 1'b0;

        // Reset state
        #12;
        chk("rst_ar_valid", ar_valid, 1'b0);
        chk("rst_r_ready", r_ready, 1'b0);
        chk("rst_data_valid", data_valid, 1'b0);
        chk("rst_full", full, 1'b0);
        chk("rst_rdata", rdata, 256'd0);
        #10;
        rst = 1'b0;
        tick;

        // Single request, ar_ready high
        ar_ready = 1'b1;
        req   = 1'b1;
        paddr = 32'h8000_1234;
        settle;
        chk("s1_ready", ready, 1'b1);
        tick;
        req = 1'b0;
        chk("s1_ar_valid", ar_valid, 1'b1);
        chk("s1_ar_addr", ar_addr, 32'h8000_1220);
        chk("s1_ar_len", ar_len, 8'd3);
        tick;
        chk("s1_ar_dropped", ar_valid, 1'b0);
        send_line(64'h1111_1111_1111_1110, -1, 4'b1000, line);
        chk("s1_dv", data_valid, 1'b1);
        chk("s1_err", err, 1'b0);
        chk("s1_rdata", rdata,
            256'h4444444444444443_3333333333333332_2222222222222221_1111111111111110);
        tick;
        chk("s1_dv_one_cycle", data_valid, 1'b0);
        chk("s1_rdata_hold", rdata,
            256'h4444444444444443_3333333333333332_2222222222222221_1111111111111110);

        // Three back-to-back requests with ar_ready low
        ar_ready = 1'b0;
        req   = 1'b1;
        paddr = 32'h0000_1000;
        settle;
        chk("s2_ready1", ready, 1'b1);
        tick;
        paddr = 32'h0000_2044;
        settle;
        chk("s2_ready2", ready, 1'b1);
        tick;
        paddr = 32'h0000_303F;
        settle;
        chk("s2_full", full, 1'b1);
        chk("s2_ready3_blocked", ready, 1'b0);
        tick;
        chk("s2_ready3_still", ready, 1'b0);
        chk("s2_addr1", ar_addr, 32'h0000_1000);
        ar_ready = 1'b1;
        tick;
        chk("s2_full_after_pop", full, 1'b0);
        chk("s2_ready3_accept", ready, 1'b1);
        tick;
        req = 1'b0;
        send_line(64'hA000_0000_0000_0000, -1, 4'b1000, line);
        chk("s2_dv1", data_valid, 1'b1);
        chk("s2_line1", rdata, line);
        tick;
        chk("s2_ar_valid2", ar_valid, 1'b1);
        chk("s2_addr2", ar_addr, 32'h0000_2040);
        tick;
        send_line(64'hB000_0000_0000_0000, -1, 4'b1000, line);
        chk("s2_dv2", data_valid, 1'b1);
        chk("s2_line2", rdata, line);
        tick;
        chk("s2_addr3", ar_addr, 32'h0000_3020);
        tick;
        send_line(64'hC000_0000_0000_0000, -1, 4'b1000, line);
        chk("s2_dv3", data_valid, 1'b1);
        chk("s2_line3", rdata, line);
        tick;
        chk("s2_idle_ar", ar_valid, 1'b0);
        chk("s2_idle_full", full, 1'b0);

        // Error beat, then a clean line
        req   = 1'b1;
        paddr = 32'h0000_0104;
        tick;
        req = 1'b0;
        tick;
        send_line(64'hD000_0000_0000_0000, 1, 4'b1000, line);
        chk("s3_dv", data_valid, 1'b1);
        chk("s3_err", err, 1'b1);
        tick;
        req   = 1'b1;
        paddr = 32'h0000_0200;
        tick;
        req = 1'b0;
        tick;
        send_line(64'hE000_0000_0000_0000, -1, 4'b1000, line);
        chk("s3_dv_clean", data_valid, 1'b1);
        chk("s3_err_clear", err, 1'b0);
        tick;

        // Flush during DATA with one request queued
        req   = 1'b1;
        paddr = 32'h0000_5000;
        tick;
        paddr = 32'h0000_6000;
        settle;
        chk("s4_ready_b", ready, 1'b1);
        tick;
        req = 1'b0;
        send_beat(64'h5555_0000_0000_0000, 2'd0, 1'b0);
        flush = 1'b1;
        req   = 1'b1;
        paddr = 32'h0000_7000;
        settle;
        chk("s4_ready_on_flush", ready, 1'b0);
        tick;
        flush = 1'b0;
        req   = 1'b0;
        send_beat(64'h5555_0000_0000_0001, 2'd0, 1'b0);
        send_beat(64'h5555_0000_0000_0002, 2'd0, 1'b0);
        send_beat(64'h5555_0000_0000_0003, 2'd0, 1'b1);
        chk("s4_no_dv", data_valid, 1'b0);
        chk("s4_idle_r_ready", r_ready, 1'b0);
        chk("s4_idle_ar", ar_valid, 1'b0);
        tick;
        chk("s4_queue_empty_ar", ar_valid, 1'b0);
        chk("s4_not_full", full, 1'b0);

        // Early r_last on beat 2 of 4
        req   = 1'b1;
        paddr = 32'h0000_8000;
        tick;
        req = 1'b0;
        tick;
        send_line(64'hF000_0000_0000_0000, -1, 4'b1010, line);
        chk("s5_dv", data_valid, 1'b1);
        chk("s5_err", err, 1'b1);
        chk("s5_line", rdata, line);
        tick;

        // Asynchronous reset mid-DATA
        ar_ready = 1'b0;
        req   = 1'b1;
        paddr = 32'h0000_9000;
        tick;
        paddr = 32'h0000_A000;
        tick;
        req = 1'b0;
        ar_ready = 1'b1;
        tick;
        req   = 1'b1;
        paddr = 32'h0000_B000;
        tick;
        req = 1'b0;
        settle;
        chk("s6_full_before", full, 1'b1);
        r_valid = 1'b1;
        r_data  = 64'h1234_5678_9ABC_DEF0;
        tick;
        r_valid = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        chk("s6_rst_ar_valid", ar_valid, 1'b0);
        chk("s6_rst_r_ready", r_ready, 1'b0);
        chk("s6_rst_dv", data_valid, 1'b0);
        chk("s6_rst_full", full, 1'b0);
        #1;
        rst = 1'b0;
        tick;
        req   = 1'b1;
        paddr = 32'h9ABC_DEF8;
        tick;
        req = 1'b0;
        chk("s6_ar_valid", ar_valid, 1'b1);
        chk("s6_ar_addr", ar_addr, 32'h9ABC_DEE0);
        tick;
        send_line(64'h0101_0101_0101_0100, -1, 4'b1000, line);
        chk("s6_dv", data_valid, 1'b1);
        chk("s6_err", err, 1'b0);
        chk("s6_line", rdata, line);
        tick;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
